// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the character-LCD Avalon responder
package lcd_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} lcd_state_e;

  localparam logic       ADDR_INSTR = 1'b0;
  localparam logic       ADDR_DATA  = 1'b1;
  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_HOME   = 8'h02;

  // Clear and both home encodings (02/03) need the long execution wait.
  function automatic logic is_long_cmd(input logic addr, input logic [7:0] data);
    return (addr == ADDR_INSTR) &&
           ((data == CMD_CLEAR) || ((data & 8'hFE) == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_avalon_responder_if.sv
// rtl/lcd_avalon_responder_if.sv - Avalon-MM bus bundle between initiator and LCD responder
interface lcd_avalon_responder_if;
  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic       waitrequest;
  logic [7:0] readdata;
  logic [1:0] response;

  modport slave (
    input  address, chipselect, byteenable, read, write, writedata,
    output waitrequest, readdata, response
  );

  modport master (
    output address, chipselect, byteenable, read, write, writedata,
    input  waitrequest, readdata, response
  );
endinterface

// File: rtl/lcd_cycle_timer.sv
// rtl/lcd_cycle_timer.sv - loadable down-counter shared by every timed LCD state
module lcd_cycle_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_done
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_avalon_responder.sv
// rtl/lcd_avalon_responder.sv - turns Avalon writes into timed HD44780 bus cycles
module lcd_avalon_responder
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES     = 2,
  parameter int EN_CYCLES        = 12,
  parameter int HOLD_CYCLES      = 2,
  parameter int EXEC_CYCLES      = 2000,
  parameter int LONG_EXEC_CYCLES = 82000
) (
  input  logic                        clk,
  input  logic                        reset,
  lcd_avalon_responder_if.slave       avl,
  output logic [7:0]                  lcd_data,
  output logic                        lcd_rs,
  output logic                        lcd_rw,
  output logic                        lcd_en,
  output logic                        busy
);

  localparam int CW = $clog2(LONG_EXEC_CYCLES) + 1;

  lcd_state_e    r_state;
  lcd_state_e    w_next;
  logic [7:0]    r_lcd_data;
  logic          r_lcd_rs;
  logic          r_lcd_en;
  logic          r_long;
  logic [7:0]    r_last_char;
  logic          w_accept;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_done;

  assign busy     = (r_state != IDLE);
  assign w_accept = (r_state == IDLE) && avl.chipselect && avl.write && avl.byteenable;

  lcd_cycle_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_next     = SETUP;
        w_load     = 1'b1;
        w_load_val = CW'(SETUP_CYCLES - 1);
      end
      SETUP: if (w_done) begin
        w_next     = PULSE;
        w_load     = 1'b1;
        w_load_val = CW'(EN_CYCLES - 1);
      end
      PULSE: if (w_done) begin
        w_next     = HOLD;
        w_load     = 1'b1;
        w_load_val = CW'(HOLD_CYCLES - 1);
      end
      HOLD: if (w_done) begin
        w_next     = EXEC;
        w_load     = 1'b1;
        w_load_val = r_long ? CW'(LONG_EXEC_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
      end
      EXEC: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // EN is registered from the next state so the pin never sees a decode glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lcd_data  <= 8'h00;
      r_lcd_rs    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_long      <= 1'b0;
      r_last_char <= 8'h00;
    end else begin
      r_state  <= w_next;
      r_lcd_en <= (w_next == PULSE);
      if (w_accept) begin
        r_lcd_data <= avl.writedata;
        r_lcd_rs   <= avl.address;
        r_long     <= is_long_cmd(avl.address, avl.writedata);
        if (avl.address == ADDR_DATA) r_last_char <= avl.writedata;
      end
    end
  end

  assign lcd_data = r_lcd_data;
  assign lcd_rs   = r_lcd_rs;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = r_lcd_en;

  assign avl.waitrequest = avl.chipselect && avl.write && busy;
  assign avl.response    = 2'b00;
  assign avl.readdata    = !(avl.chipselect && avl.read) ? 8'h00 :
                           (avl.address == ADDR_INSTR) ? {busy, 7'b0} : r_last_char;

endmodule

// File: tb/tb_lcd_avalon_responder.sv
// tb/tb_lcd_avalon_responder.sv - scoreboard bench for the LCD Avalon responder
module tb_lcd_avalon_responder;

  localparam int S_CYC = 2;
  localparam int E_CYC = 3;
  localparam int H_CYC = 2;
  localparam int X_CYC = 5;
  localparam int L_CYC = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       busy;

  lcd_avalon_responder_if avl();

  lcd_avalon_responder #(
    .SETUP_CYCLES(S_CYC), .EN_CYCLES(E_CYC), .HOLD_CYCLES(H_CYC),
    .EXEC_CYCLES(X_CYC), .LONG_EXEC_CYCLES(L_CYC)
  ) dut (
    .clk(clk), .reset(reset), .avl(avl),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_bytes[$];
  int         exp_busy[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int busy_len(input logic a, input logic [7:0] d);
    int ex;
    ex = (a == 1'b0 && d >= 8'h01 && d <= 8'h03) ? L_CYC : X_CYC;
    return S_CYC + E_CYC + H_CYC + ex;
  endfunction

  // Present a write (phase: posedge+1) and hold it until the slave stops stalling.
  task automatic do_write(input logic a, input logic [7:0] d, input logic be, output int stalls);
    avl.chipselect = 1'b1; avl.write = 1'b1; avl.byteenable = be;
    avl.address = a; avl.writedata = d; avl.read = 1'b0;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!avl.waitrequest) break;
      stalls++;
      if (stalls > 500) begin
        check("write_stall_timeout", stalls, 0);
        break;
      end
    end
    if (be) begin
      exp_bytes.push_back({a, d});
      exp_busy.push_back(busy_len(a, d));
    end
    @(posedge clk); #1;
    avl.chipselect = 1'b0; avl.write = 1'b0; avl.byteenable = 1'b0;
  endtask

  task automatic do_read(input logic a, input logic [7:0] exp, input string name);
    avl.chipselect = 1'b1; avl.read = 1'b1; avl.address = a;
    @(negedge clk);
    check(name, avl.readdata, exp);
    check({name, "_wait"}, avl.waitrequest, 0);
    @(posedge clk); #1;
    avl.chipselect = 1'b0; avl.read = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  // Monitor: each EN rise carries the next issued byte; widths and busy spans checked.
  int   busy_run = 0;
  int   en_run = 0;
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0; en_run = 0; prev_en = 1'b0; prev_busy = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (lcd_en) en_run++;
      if (lcd_en && !prev_en) begin
        check("setup_len", busy_run, S_CYC + 1);
        check("lcd_rw", lcd_rw, 0);
        check("response", avl.response, 0);
        if (exp_bytes.size() == 0) begin
          check("unexpected_en_pulse", 1, 0);
        end else begin
          logic [8:0] e;
          e = exp_bytes.pop_front();
          check("lcd_rs", lcd_rs, e[8]);
          check("lcd_data", lcd_data, e[7:0]);
        end
      end
      if (!lcd_en && prev_en) begin
        check("en_width", en_run, E_CYC);
        en_run = 0;
      end
      if (!busy && prev_busy) begin
        if (exp_busy.size() == 0) check("unexpected_busy", 1, 0);
        else check("busy_len", busy_run, exp_busy.pop_front());
        busy_run = 0;
      end
      prev_en = lcd_en;
      prev_busy = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int issued;
    logic a;
    logic [7:0] d;
    logic be;

    reset = 1'b1;
    avl.chipselect = 1'b0; avl.write = 1'b0; avl.read = 1'b0;
    avl.byteenable = 1'b0; avl.address = 1'b0; avl.writedata = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_lcd_en", lcd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_lcd_data", lcd_data, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    @(posedge clk); #1;
    do_read(1'b1, 8'h00, "rst_char");

    // Plain instruction: no stall, latched the following cycle.
    do_write(1'b0, 8'h38, 1'b1, st);
    check("instr_stalls", st, 0);
    @(negedge clk);
    check("instr_lcd_data", lcd_data, 8'h38);
    check("instr_lcd_rs", lcd_rs, 0);
    wait_idle();

    // Back-to-back characters; second one stalls for the full busy span.
    do_write(1'b1, 8'h48, 1'b1, st);
    check("h_stalls", st, 0);
    do_write(1'b1, 8'h69, 1'b1, st);
    check("i_stalls", st, busy_len(1'b1, 8'h48));
    do_read(1'b0, 8'h80, "rd_busy");
    wait_idle();
    do_read(1'b0, 8'h00, "rd_idle");
    do_read(1'b1, 8'h69, "rd_char");
    @(negedge clk);
    check("rd_inactive", avl.readdata, 0);
    @(posedge clk); #1;

    // Long vs short exec for the same byte on different addresses.
    do_write(1'b0, 8'h01, 1'b1, st);
    wait_idle();
    do_write(1'b1, 8'h01, 1'b1, st);
    wait_idle();
    do_write(1'b0, 8'h03, 1'b1, st);
    wait_idle();

    // byteenable=0 write completes and is ignored.
    do_write(1'b1, 8'h77, 1'b0, st);
    check("be0_stalls", st, 0);
    @(negedge clk);
    check("be0_busy", busy, 0);
    @(posedge clk); #1;

    // Reset in the middle of the EN pulse.
    do_write(1'b1, 8'h55, 1'b1, st);
    st = 0;
    @(negedge clk);
    while (!lcd_en && st < 50) begin
      st++;
      @(negedge clk);
    end
    check("reach_pulse", lcd_en, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    avl.chipselect = 1'b1; avl.write = 1'b1; avl.byteenable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_busy.delete();
    exp_bytes.delete();
    @(negedge clk);
    check("abort_lcd_en", lcd_en, 0);
    check("abort_busy", busy, 0);
    check("abort_wait", avl.waitrequest, 0);
    @(posedge clk); #1;
    avl.chipselect = 1'b0; avl.write = 1'b0;
    do_write(1'b0, 8'h0C, 1'b1, st);
    check("post_reset_stalls", st, 0);
    wait_idle();

    // Random traffic, 37.5% write density.
    issued = 0;
    while (issued < 200) begin
      if ($urandom_range(0, 7) < 3) begin
        a  = 1'($urandom_range(0, 1));
        d  = 8'($urandom_range(0, 255));
        if (a == 1'b0 && $urandom_range(0, 9) == 0) d = 8'($urandom_range(1, 3));
        be = ($urandom_range(0, 9) != 0);
        do_write(a, d, be, st);
        if (be) issued++;
      end else begin
        @(posedge clk); #1;
      end
    end
    wait_idle();
    check("bytes_left", exp_bytes.size(), 0);
    check("busy_left", exp_busy.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_avalon_responder.md
Name: lcd_avalon_responder

Overview:
- Avalon-MM responder (slave) for the character-LCD interface driven by hello_lcd and similar initiators.
- Accepts 8-bit writes: address 0 is an HD44780 instruction, address 1 is an ASCII data byte.
- Converts each accepted write into a timed LCD bus cycle (RS/RW/EN/DATA) and holds waitrequest until the LCD execution time has elapsed.
- Sits between the initiator and the LCD pins.

Parameters:
- SETUP_CYCLES, 2, clocks RS/DATA stable before EN rises (≥40 ns at 50 MHz).
- EN_CYCLES, 12, clocks EN held high (≥230 ns).
- HOLD_CYCLES, 2, clocks RS/DATA held after EN falls.
- EXEC_CYCLES, 2000, post-cycle wait for normal instruction or data (40 µs at 50 MHz).
- LONG_EXEC_CYCLES, 82000, post-cycle wait for clear (8'h01) or home (8'h02/8'h03) at address 0 (1.64 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  1  0 = instruction register, 1 = data register
- chipselect  in  1  Avalon chipselect
- byteenable  in  1  byte lane enable
- read  in  1  read strobe
- write  in  1  write strobe
- waitrequest  out  1  stall; initiator holds write and writedata while high
- readdata  out  8  status/readback
- response  out  2  always 2'b00 (OKAY)
- writedata  in  8  instruction or character
- lcd_data  out  8  LCD DB7..DB0
- lcd_rs  out  1  register select (0 = instr, 1 = data)
- lcd_rw  out  1  always 0 (write-only)
- lcd_en  out  1  enable strobe
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: one clock; synchronous, active-high.
- Reset values: state=IDLE, lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, busy=0, counter=0. Reset mid-cycle aborts immediately; lcd_en=0 on the next edge.
- FSM: IDLE -> SETUP -> PULSE -> HOLD -> EXEC -> IDLE.
  - IDLE: on chipselect&write&byteenable, latch writedata into lcd_data and address into lcd_rs, select exec length (long if address==0 and writedata ∈ {01,02,03}), load counter=SETUP_CYCLES-1, go to SETUP.
  - SETUP: count to 0, then lcd_en=1, load EN_CYCLES-1, go to PULSE.
  - PULSE: count to 0, then lcd_en=0, load HOLD_CYCLES-1, go to HOLD.
  - HOLD: count to 0, then load the exec length minus 1, go to EXEC.
  - EXEC: count to 0, then go to IDLE. lcd_data and lcd_rs hold their last value.
- Counter width: $clog2(LONG_EXEC_CYCLES)+1. Every parameter must be ≥1.
- Total busy time per write: SETUP+EN+HOLD+EXEC clocks.
- waitrequest (combinational) = chipselect & write & busy.
  - A write presented in IDLE completes in that same cycle (waitrequest=0) and is latched exactly once.
  - A write arriving while busy stalls. It is accepted in the first IDLE cycle, so back-to-back writes leave no gap beyond that IDLE cycle.
- Write with byteenable=0: completes (no stall when idle), ignored, no LCD cycle, state unchanged.
- Read (combinational, zero wait states, never stalls):
  - address 0: readdata = {busy, 7'b0}.
  - address 1: readdata = last latched character.
  - readdata = 8'h00 when read is not active.
- Simultaneous read and write: write semantics take precedence for waitrequest. readdata still reflects pre-edge state.
- The initiator changing address or writedata while stalled is a protocol violation; the block samples only at acceptance.

Decomposition:
- Package lcd_pkg:
  - state enum lcd_state_e {IDLE, SETUP, PULSE, HOLD, EXEC}
  - ADDR_INSTR=1'b0, ADDR_DATA=1'b1
  - CMD_CLEAR=8'h01, CMD_HOME=8'h02
- One sub-module, lcd_cycle_timer: loadable down-counter with a done flag. It is shared by all timed states.

Test Plan (parameters 2/3/2/5/20):
- Idle write addr=0, data=8'h38 -> waitrequest=0 that cycle. lcd_rs=0, lcd_data=38 next cycle. lcd_en high for exactly 3 clocks after 2 setup clocks. busy high for 12 clocks total.
- Write addr=1 data 'H' immediately followed by 'i' held with write=1 -> second write stalls 12 clocks. lcd_rs=1. Exactly two EN pulses, carrying 8'h48 then 8'h69.
- Write addr=0 data=8'h01 -> busy lasts 2+3+2+20=27 clocks. Write addr=1 data=8'h01 -> busy lasts 12 clocks.
- Read addr=0 mid-cycle -> readdata=8'h80, waitrequest=0. After completion -> 8'h00. Read addr=1 after 'i' -> 8'h69.
- Assert reset during PULSE -> lcd_en=0, busy=0, waitrequest=0 next clock. A subsequent write is accepted normally.
- Random 37.5% chipselect/write stimulus, 200 writes -> monitor shows LCD bytes in issue order, none dropped or duplicated, response always 2'b00.
